// File: rtl/hs_req_responder.sv
// Responder end of the 4-phase req/ack handshake: synchronizes data_req, buffers words in a FIFO
// and streams them out as valid/ready. Optional sequence checker enabled by macro HS_SEQ_CHECK_EN.
module hs_req_responder #(
  parameter int DW      = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int SEQ_MOD = 8
) (
  input  logic             clk_b,
  input  logic             rst,
  input  logic             data_req,
  input  logic [DW-1:0]    data,
  output logic             data_ack,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef HS_SEQ_CHECK_EN
  ,
  output logic             seq_err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SEQ_MOD < 1) begin : g_bad_param
    $error("hs_req_responder: DEPTH must be a power of 2 >= 2 and SEQ_MOD >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               req_s1_q, req_s_q;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      odata_q, odata_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [DW-1:0]      mem_d [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic               capture_s, pop_s, not_full_s;
`ifdef HS_SEQ_CHECK_EN
  logic [DW-1:0]      exp_q, exp_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    xfer_d     = xfer_q;
    mem_d      = mem_q;
    capture_s  = 1'b0;
    // Full test uses the registered count, so a same-cycle pop cannot enable a capture.
    not_full_s = (cnt_q < CW'(DEPTH));
    pop_s      = valid_q & out_ready;
    case (state_q)
      IDLE: begin
        if (req_s_q && not_full_s) begin
          capture_s = 1'b1;
          ack_d     = 1'b1;
          state_d   = ACK;
        end else if (req_s_q) begin
          state_d = STALL;
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (not_full_s) begin
          capture_s = 1'b1;
          ack_d     = 1'b1;
          state_d   = ACK;
        end else begin
          ack_d = 1'b0;
        end
      end
      ACK: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (capture_s) begin
      mem_d[wr_q] = data;
      wr_d        = wr_q + AW'(1);
      xfer_d      = xfer_q + CNT_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    cnt_d   = cnt_q + CW'(capture_s) - CW'(pop_s);
    valid_d = (cnt_d != CW'(0));
    odata_d = mem_d[rd_d];
`ifdef HS_SEQ_CHECK_EN
    exp_d = exp_q;
    err_d = err_q;
    if (capture_s) begin
      if (data != exp_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      exp_d = DW'((32'(data) + 32'd1) % 32'(SEQ_MOD));
    end else begin
      exp_d = exp_q;
    end
`endif
  end

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_s1_q <= 1'b0;
      req_s_q  <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      odata_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      xfer_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef HS_SEQ_CHECK_EN
      exp_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_s1_q <= data_req;
      req_s_q  <= req_s1_q;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      odata_q  <= odata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      mem_q    <= mem_d;
`ifdef HS_SEQ_CHECK_EN
      exp_q    <= exp_d;
      err_q    <= err_d;
`endif
    end
  end

  assign data_ack  = ack_q;
  assign out_valid = valid_q;
  assign out_data  = odata_q;
  assign xfer_cnt  = xfer_q;
`ifdef HS_SEQ_CHECK_EN
  assign seq_err   = err_q;
`endif

endmodule
